// File: rtl/obsidian_alu_pipe.sv
// obsidian_alu_pipe: valid/ready ALU with a one-cycle path for simple ops
// and a bit-serial shift-add multiplier that takes WIDTH cycles.
module obsidian_alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SAL = 4'b0110;
  localparam logic [3:0] OP_SAR = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_c;
  logic                   r_zero;
  logic                   r_carry;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic                   r_busy;
  logic [2*WIDTH-1:0]     r_prod;
  logic [WIDTH-1:0]       r_mcand;
  logic [SHW-1:0]         r_cnt;

  logic                   w_accept;
  logic                   w_is_mul;
  logic [WIDTH:0]         w_sum;
  logic [WIDTH:0]         w_diff;
  logic [WIDTH:0]         w_shl;
  logic [WIDTH:0]         w_shr;
  logic [WIDTH:0]         w_sar;
  logic [WIDTH-1:0]       w_res;
  logic                   w_res_carry;
  logic                   w_res_ovf;
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_prod_nxt;
  logic                   w_last;

  // Accept from IDLE, or from DONE when the current result leaves this edge
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (alu_control == OP_MUL);

  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign busy      = r_busy;

  // Wide intermediates keep the carry / shifted-out bit at a fixed position
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_shl  = {1'b0, a} << shamt;
  assign w_shr  = {a, 1'b0} >> shamt;
  assign w_sar  = $signed({a, 1'b0}) >>> shamt;

  // Single-cycle result for every opcode except MUL
  always_comb begin
    w_res       = '0;
    w_res_carry = 1'b0;
    w_res_ovf   = 1'b0;
    case (alu_control)
      OP_ADD: begin
        w_res       = w_sum[WIDTH-1:0];
        w_res_carry = w_sum[WIDTH];
        w_res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res       = w_diff[WIDTH-1:0];
        w_res_carry = w_diff[WIDTH];
        w_res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_AND: w_res = a & b;
      OP_SLL, OP_SAL: begin
        w_res       = w_shl[WIDTH-1:0];
        w_res_carry = w_shl[WIDTH];
      end
      OP_SRL: begin
        w_res       = w_shr[WIDTH:1];
        w_res_carry = w_shr[0];
      end
      OP_SAR: begin
        w_res       = w_sar[WIDTH:1];
        w_res_carry = w_sar[0];
      end
      default: begin
        w_res       = '0;
        w_res_carry = 1'b0;
        w_res_ovf   = 1'b0;
      end
    endcase
  end

  // One shift-add step: multiplier lives in the low half and shifts out as the product grows
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_last     = (r_cnt == SHW'(WIDTH - 1));

  // Control FSM with registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_zero      <= 1'b1;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + SHW'(1);
          if (w_last) begin
            r_c         <= w_prod_nxt[WIDTH-1:0];
            r_zero      <= (w_prod_nxt[WIDTH-1:0] == '0);
            r_carry     <= |w_prod_nxt[2*WIDTH-1:WIDTH];
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        default: begin
          if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          if (w_accept) begin
            if (w_is_mul) begin
              r_prod      <= {{WIDTH{1'b0}}, b};
              r_mcand     <= a;
              r_cnt       <= '0;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else begin
              r_c         <= w_res;
              r_zero      <= (w_res == '0);
              r_carry     <= w_res_carry;
              r_ovf       <= w_res_ovf;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/obsidian_alu_pipe.md
OBSIDIAN_ALU_PIPE -- requirements
Module: obsidian_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 8, power of two).
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 alu_control  input  4  opcode: 0000 ADD, 0001 SUB, 0010 OR, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SAL, 0111 SAR, 1000 AND, 1001 MUL; others reserved.
REQ-010 shamt  input  SHW  shift amount for opcodes 0100-0111.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 c  output  WIDTH  registered result.
REQ-014 zero  output  1  c == 0.
REQ-015 carry  output  1  carry/borrow/shifted-out bit.
REQ-016 overflow  output  1  signed overflow.
REQ-017 busy  output  1  high while in MUL state.

Function
REQ-018 Handshake: an operation SHALL be accepted on a rising edge where in_valid && in_ready; a, b, alu_control and shamt SHALL be sampled only at acceptance.
REQ-019 A result SHALL transfer on a rising edge where out_valid && out_ready; c, zero, carry and overflow SHALL stay stable while out_valid && !out_ready.
REQ-020 FSM states: IDLE, MUL, DONE.
REQ-021 IDLE: in_ready=1; accept of non-MUL opcode -> DONE with result registered on the same edge; accept of MUL -> MUL.
REQ-022 MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then DONE; in_ready=0, busy=1, out_valid=0.
REQ-023 DONE: out_valid=1; in_ready = out_ready; transfer without new accept -> IDLE; transfer with simultaneous accept -> handled as accept from IDLE (back-to-back, no bubble).
REQ-024 Latency: non-MUL out_valid high the cycle after acceptance; MUL out_valid high WIDTH+1 cycles after acceptance; sustained non-MUL throughput one op per cycle while out_ready=1.
REQ-025 ADD: c=(a+b) mod 2^WIDTH; carry=bit WIDTH of sum; overflow=operands same sign and result sign differs.
REQ-026 SUB: c=(a-b) mod 2^WIDTH; carry=1 iff a<b unsigned (borrow); overflow=operand signs differ and result sign differs from a.
REQ-027 OR/XOR/AND: bitwise; carry=0, overflow=0.
REQ-028 SLL and SAL: c=a<<shamt, zero fill; SRL: logical right; SAR: right with sign fill; carry=last bit shifted out, 0 when shamt=0; overflow=0.
REQ-029 MUL: c=low WIDTH bits of unsigned a*b; carry=1 iff upper WIDTH bits nonzero; overflow=0.
REQ-030 Reserved opcode: c=0, zero=1, carry=0, overflow=0, normal 1-cycle latency.
REQ-031 zero SHALL be derived from the registered c, never from in-flight MUL partial products.
REQ-032 in_valid while in_ready=0 SHALL be ignored without side effect; requester holds it.

Reset
REQ-033 rst_n low SHALL asynchronously force state=IDLE, c=0, zero=1, carry=0, overflow=0, out_valid=0, busy=0; in_ready=1 once rst_n high.
REQ-034 Reset during MUL or DONE SHALL discard the operation; no result presented after release.
REQ-035 First acceptance possible on first rising edge with rst_n high.

Verification
REQ-036 WIDTH=32, a=0x0000BCDF, b=0x0000354F, ADD, out_ready=1 -> next cycle c=0x0000F22E, carry=0, overflow=0, zero=0; SUB -> c=0x00008790, carry=0.
REQ-037 Same operands, MUL -> busy 32 cycles, out_valid at cycle 33, c=0x275473D1, carry=0; in_ready=0 throughout MUL.
REQ-038 ADD a=0x7FFFFFFF, b=0x00000001 -> c=0x80000000, overflow=1, carry=0; SUB a=b=0x12345678 -> c=0, zero=1, carry=0.
REQ-039 SAR a=0x80000000 shamt=3 -> c=0xF0000000, carry=0; SRL a=0x0000000F shamt=2 -> c=0x00000003, carry=1; SLL shamt=0 -> c=a, carry=0.
REQ-040 Backpressure: out_ready=0 for 5 cycles after ADD result -> c stable, in_ready=0; out_ready=1 with in_valid=1 (XOR) -> transfer and accept same edge, XOR result next cycle.
REQ-041 rst_n low at MUL cycle 10 -> outputs at reset values immediately, out_valid never asserted for aborted MUL; next ADD after release completes normally.
